inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch front-end feeding the fetch/decode pipeline register.
//  Reads instruction words from program memory over a req/ack handshake and
//  splits each word into opcode and operand field. Supports a downstream stall,
//  a one-entry skid buffer and a branch redirect with flush.
// PARAMETERS
//  PC_W          8    program counter / instruction address width
//  OPCODE_W      5    opcode width; opcode = imem_data[OPCODE_W+FIELD_W-1:FIELD_W]
//  FIELD_W       10   operand field width; field = imem_data[FIELD_W-1:0]
//  RESET_VECTOR  0    first fetch address after reset
//  HALT_OPCODE   5'h1F opcode that stops fetching (HALT_DETECT_EN only)
// PORTS
//  clk          in   1                 clock; all state changes on posedge
//  reset        in   1                 asynchronous, active-high reset
//  stall        in   1                 downstream cannot accept; hold outputs
//  branch_en    in   1                 one-cycle redirect request
//  branch_addr  in   PC_W              redirect target
//  imem_req     out  1                 memory read request (registered)
//  imem_addr    out  PC_W              read address, stable while imem_req=1
//  imem_data    in   OPCODE_W+FIELD_W  read data, valid when imem_ack=1
//  imem_ack     in   1                 read complete; sampled only when imem_req=1
//  opcode_out   out  OPCODE_W          opcode to pipeline register (0 = NOP)
//  field_out    out  FIELD_W           operand field to pipeline register
//  inst_valid   out  1                 opcode_out/field_out hold a real instruction
//  halted       out  1                 fetch stopped on HALT_OPCODE; 0 if feature off
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, imem_req=0, imem_addr=0, opcode_out=0, field_out=0,
//    inst_valid=0, halted=0, skid empty, state=IDLE.
//  - States: IDLE -> REQ (next cycle, unconditional).
//    REQ: imem_req=1, imem_addr=pc_fetch. On ack: pc_fetch+1 (wraps mod 2**PC_W).
//      Stay in REQ (back-to-back, new addr next cycle) if skid stays empty;
//      go WAIT_SLOT if word went to skid.
//    WAIT_SLOT: imem_req=0; when skid drains -> REQ next cycle.
//    DISCARD: imem_req=1 held until ack; acked data dropped; -> REQ at branch_addr.
//    HALT: imem_req=0 until branch_en.
//  - Consumption: instruction consumed in any cycle with inst_valid=1 and stall=0.
//  - Acked word priority: outputs if free/being consumed; else skid.
//    Output refill: skid first, then fresh acked word; otherwise bubble
//    (inst_valid=0, opcode_out=0, field_out=0).
//  - Latency: ack in cycle t -> opcode_out/field_out/inst_valid valid at t+1.
//    Zero-wait memory sustains 1 instruction/cycle.
//  - stall=1 with inst_valid=1: outputs frozen bit-exact.
//    stall while inst_valid=0: no effect.
//  - branch_en (priority over stall and ack), next cycle:
//      inst_valid=0, outputs=NOP, skid cleared, pc_fetch=branch_addr, halted=0.
//    If a request is outstanding and not acked in the branch cycle: state=DISCARD.
//    Ack coinciding with branch_en: that word is dropped.
//  - imem_addr and imem_req never change while imem_req=1 and imem_ack=0.
//  - Reset asserted mid-request: immediate return to reset values; no ack honoured.
// CONFIGURATION
//  HALT_DETECT_EN defined:
//    - Instruction with opcode==HALT_OPCODE loaded into outputs sets halted=1 and
//      moves the FSM to HALT after any outstanding ack (that word is dropped).
//    - The halt instruction itself is presented and consumed normally.
//  HALT_DETECT_EN undefined: no halt logic, halted tied 0, HALT_OPCODE is an
//    ordinary opcode.
// TESTING
//  1 Reset release, ack held 0 -> imem_req=1 at addr 0 from cycle 2.
//    All outputs 0 before that.
//  2 Zero-wait memory, words 0x0401,0x0802,0x0C03 -> opcode 1,2,3 / field 1,2,3
//    on consecutive cycles; imem_addr 0,1,2,3.
//  3 Memory acks every 3rd cycle -> imem_addr stable while waiting.
//    inst_valid=1 one cycle per ack, bubbles (opcode 0) between.
//  4 stall=1 for 4 cycles during zero-wait stream -> outputs frozen, one word in
//    skid, imem_req=0. On release: skid word next cycle, then fetch resumes,
//    no loss or duplication.
//  5 branch_en, branch_addr=0x40 while req outstanding -> late ack dropped,
//    inst_valid=0, next imem_addr=0x40.
//  6 HALT_DETECT_EN, opcode 0x1F fetched -> halted=1, imem_req=0.
//    branch_en to 0x10 -> halted=0, fetch resumes at 0x10.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front-end with skid buffer, branch redirect and optional halt detection (HALT_DETECT_EN)
module inst_fetch_unit #(
   parameter int                  PC_W         = 8,
   parameter int                  OPCODE_W     = 5,
   parameter int                  FIELD_W      = 10,
   parameter logic [PC_W-1:0]     RESET_VECTOR = '0,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE  = 5'h1F
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        branch_en,
   input  logic [PC_W-1:0]             branch_addr,
   output logic                        imem_req,
   output logic [PC_W-1:0]             imem_addr,
   input  logic [OPCODE_W+FIELD_W-1:0] imem_data,
   input  logic                        imem_ack,
   output logic [OPCODE_W-1:0]         opcode_out,
   output logic [FIELD_W-1:0]          field_out,
   output logic                        inst_valid,
   output logic                        halted
);

`ifdef HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_SLOT,
      S_DISCARD,
      S_HALT
   } state_t;

   state_t                state;
   logic [PC_W-1:0]       pc_fetch;
   logic [PC_W-1:0]       pc_inc;
   logic                  skid_valid;
   logic [OPCODE_W-1:0]   skid_opcode;
   logic [FIELD_W-1:0]    skid_field;
   logic                  halt_q;

   logic [OPCODE_W-1:0]   mem_opcode;
   logic [FIELD_W-1:0]    mem_field;
   logic [OPCODE_W-1:0]   load_opcode;
   logic                  ack_take;
   logic                  consume;
   logic                  out_free;
   logic                  load_skid;
   logic                  load_fresh;
   logic                  to_skid;
   logic                  outstanding;
   logic                  halt_hit;

   assign mem_opcode = imem_data[OPCODE_W+FIELD_W-1:FIELD_W];
   assign mem_field  = imem_data[FIELD_W-1:0];
   assign pc_inc     = pc_fetch + PC_ONE;
   assign halted     = HALT_EN ? halt_q : 1'b0;

   // Steering of the acked word and the output register refill for this cycle
   always_comb begin
      ack_take    = 1'b0;
      consume     = 1'b0;
      out_free    = 1'b0;
      load_skid   = 1'b0;
      load_fresh  = 1'b0;
      to_skid     = 1'b0;
      outstanding = 1'b0;
      load_opcode = '0;
      halt_hit    = 1'b0;

      // Only a REQ-state ack carries a live word; DISCARD acks and acks
      // coinciding with a redirect are thrown away.
      ack_take    = imem_req && imem_ack && (state == S_REQ) && !branch_en;
      consume     = inst_valid && !stall;
      out_free    = !inst_valid || consume;
      load_skid   = out_free && skid_valid;
      load_fresh  = out_free && !skid_valid && ack_take;
      to_skid     = ack_take && !load_fresh;
      outstanding = imem_req && !imem_ack;
      load_opcode = load_skid ? skid_opcode : mem_opcode;
      halt_hit    = HALT_EN && (load_skid || load_fresh) &&
                    (load_opcode == HALT_OPCODE) && !branch_en;
   end

   // Fetch FSM together with the output register, skid buffer and halt flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pc_fetch    <= RESET_VECTOR;
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         opcode_out  <= '0;
         field_out   <= '0;
         inst_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         skid_opcode <= '0;
         skid_field  <= '0;
         halt_q      <= 1'b0;
      end else if (branch_en) begin
         // Redirect wins over stall and ack: flush everything in flight.
         inst_valid <= 1'b0;
         opcode_out <= '0;
         field_out  <= '0;
         skid_valid <= 1'b0;
         pc_fetch   <= branch_addr;
         halt_q     <= 1'b0;
         if (outstanding) begin
            // Request address must stay put until the memory answers.
            state <= S_DISCARD;
         end else begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= branch_addr;
         end
      end else begin
         if (load_skid) begin
            opcode_out <= skid_opcode;
            field_out  <= skid_field;
            inst_valid <= 1'b1;
         end else if (load_fresh) begin
            opcode_out <= mem_opcode;
            field_out  <= mem_field;
            inst_valid <= 1'b1;
         end else if (consume) begin
            opcode_out <= '0;
            field_out  <= '0;
            inst_valid <= 1'b0;
         end

         // A word fetched alongside a halt instruction is dropped.
         if (to_skid && !halt_hit) begin
            skid_valid  <= 1'b1;
            skid_opcode <= mem_opcode;
            skid_field  <= mem_field;
         end else if (load_skid) begin
            skid_valid <= 1'b0;
         end

         if (halt_hit) begin
            halt_q <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               state     <= S_REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc_fetch;
            end
            S_REQ: begin
               if (halt_hit) begin
                  if (outstanding) begin
                     state <= S_DISCARD;
                  end else begin
                     state    <= S_HALT;
                     imem_req <= 1'b0;
                  end
               end else if (ack_take) begin
                  pc_fetch <= pc_inc;
                  if (to_skid) begin
                     // Both slots occupied: stop requesting until the skid drains.
                     state    <= S_WAIT_SLOT;
                     imem_req <= 1'b0;
                  end else begin
                     imem_addr <= pc_inc;
                  end
               end
            end
            S_WAIT_SLOT: begin
               if (halt_hit) begin
                  state <= S_HALT;
               end else if (!skid_valid || load_skid) begin
                  state     <= S_REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc_fetch;
               end
            end
            S_DISCARD: begin
               if (imem_ack) begin
                  if (halt_q) begin
                     state    <= S_HALT;
                     imem_req <= 1'b0;
                  end else begin
                     state     <= S_REQ;
                     imem_addr <= pc_fetch;
                  end
               end
            end
            S_HALT: begin
               imem_req <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
